// File: rtl/series_job_sequencer.sv
// Operand FIFO + job launcher for the series-evaluation core; one core job per operand, result held in a valid/ready register.
// Optional feature: define SEQ_TIMEOUT_EN to abort a job that has not reported done within TIMEOUT_CYC WAIT cycles.
module series_job_sequencer #(
  parameter int DW          = 16,
  parameter int RW          = 16,
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_x,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [RW-1:0] out_y,
  output logic          out_err,
  output logic          core_start,
  output logic [DW-1:0] core_x,
  input  logic          core_done,
  input  logic [RW-1:0] core_y,
  output logic          core_rst,
  output logic          busy,
  output logic [7:0]    jobs_done
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, START, WAIT} state_t;
  state_t state;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          fifo_full, fifo_empty, push, pop, out_slot_free;

  assign fifo_full     = (count == (AW+1)'(DEPTH));
  assign fifo_empty    = (count == '0);
  assign in_ready      = !fifo_full;
  assign push          = in_valid && !fifo_full;
  assign out_slot_free = !out_valid || out_ready;
  assign pop           = (state == IDLE) && !fifo_empty && out_slot_free;

  // Storage carries no reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_x;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef SEQ_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  logic [CW-1:0] wait_cnt;
  logic          err_q, abort_q;
  assign out_err  = err_q;
  assign core_rst = abort_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
  assign out_err  = 1'b0;
  assign core_rst = 1'b0;
`endif

  // Job sequencing and output register; a capture on the consuming edge keeps out_valid high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      core_start <= 1'b0;
      core_x     <= '0;
      out_valid  <= 1'b0;
      out_y      <= '0;
      busy       <= 1'b0;
      jobs_done  <= '0;
`ifdef SEQ_TIMEOUT_EN
      wait_cnt   <= '0;
      err_q      <= 1'b0;
      abort_q    <= 1'b0;
`endif
    end else begin
      core_start <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
      abort_q    <= 1'b0;
`endif
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            core_x     <= mem[rd_ptr];
            core_start <= 1'b1;
            busy       <= 1'b1;
            state      <= START;
          end
        end
        START: begin
          state <= WAIT;
`ifdef SEQ_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        WAIT: begin
          if (core_done) begin
            out_y     <= core_y;
            out_valid <= 1'b1;
            jobs_done <= jobs_done + 8'd1;
            busy      <= 1'b0;
            state     <= IDLE;
`ifdef SEQ_TIMEOUT_EN
            err_q     <= 1'b0;
          end else if (wait_cnt == CW'(TIMEOUT_CYC - 1)) begin
            abort_q   <= 1'b1;
            out_y     <= '1;
            err_q     <= 1'b1;
            out_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            wait_cnt  <= wait_cnt + 1'b1;
`endif
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_series_job_sequencer.sv
// Scoreboard bench for series_job_sequencer: directed operands, behavioural core model, decoupled result monitor.
`timescale 1ns/1ps
module tb_series_job_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, out_err;
  logic [15:0] in_x, out_y, core_x, core_y;
  logic        core_start, core_done, core_rst, busy;
  logic [7:0]  jobs_done;

  series_job_sequencer #(.DW(16), .RW(16), .DEPTH(4), .TIMEOUT_CYC(10)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_err(out_err),
    .core_start(core_start), .core_x(core_x), .core_done(core_done), .core_y(core_y),
    .core_rst(core_rst), .busy(busy), .jobs_done(jobs_done)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [15:0] y; logic err; } exp_t;
  exp_t sb[$];

  int checks = 0;
  int failures = 0;
  int core_lat = 20;
  int core_cnt = 0;
  int start_cnt = 0;
  int cyc = 0;
  int start_cyc = 0;
  int abort_cyc = 0;
  int exp_jobs = 0;
  logic [15:0] core_lx = '0;
  logic model_done = 1'b0;
  logic spur_done = 1'b0;

  assign core_done = model_done | spur_done;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Core model: result = x - 11, done core_lat cycles after the start cycle; core_lat 0 never finishes.
  initial begin
    core_y = '0;
    forever begin
      @(posedge clk);
      #1;
      model_done = 1'b0;
      if (rst || core_rst) core_cnt = 0;
      else if (core_start) begin
        core_cnt = core_lat;
        core_lx  = core_x;
      end else if (core_cnt > 0) begin
        core_cnt--;
        if (core_cnt == 0) begin
          model_done = 1'b1;
          core_y     = core_lx - 16'd11;
        end
      end
    end
  end

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst && core_start) begin
      start_cnt++;
      start_cyc = cyc;
    end
    if (!rst && core_rst) abort_cyc = cyc;
  end

  // Monitor: every handshake seen at the falling edge completes on the next rising edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_result actual=%0h expected=none", out_y);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("out_y", 32'(out_y), 32'(e.y));
        checkOutput("out_err", 32'(out_err), 32'(e.err));
      end
    end
  end

  task automatic applyStimulus(input logic [15:0] x, input logic [15:0] y, input logic err);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_x     = x;
    while (!in_ready && n < 300) begin
      tick(1);
      n++;
    end
    if (!in_ready) begin
      checkOutput("push_timeout", 32'(in_ready), 32'd1);
    end else begin
      @(posedge clk);
      sb.push_back('{y: y, err: err});
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic waitDrain(input string name);
    int n;
    n = 0;
    while (!(sb.size() == 0 && !out_valid && !busy) && n < 1000) begin
      tick(1);
      n++;
    end
    checkOutput(name, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int s0;
    int n;
    rst = 1'b1; in_valid = 1'b0; in_x = '0; out_ready = 1'b1;
    tick(3);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_jobs_done", 32'(jobs_done), 32'd0);
    checkOutput("rst_core_start", 32'(core_start), 32'd0);
    rst = 1'b0;
    tick(2);

    $display("[TB] single job");
    core_lat = 20;
    applyStimulus(16'h0200, 16'h01F5, 1'b0);
    @(negedge clk); checkOutput("start_c1", 32'(core_start), 32'd0);
    @(negedge clk); checkOutput("start_c2", 32'(core_start), 32'd1);
    checkOutput("core_x", 32'(core_x), 32'h0200);
    @(negedge clk); checkOutput("start_c3", 32'(core_start), 32'd0);
    tick(1);
    waitDrain("drain_single");
    exp_jobs = 1;
    checkOutput("jobs_single", 32'(jobs_done), 32'(exp_jobs));

    $display("[TB] fifo full");
    core_lat = 3;
    out_ready = 1'b0;
    applyStimulus(16'h0010, 16'h0005, 1'b0);
    applyStimulus(16'h0100, 16'h00F5, 1'b0);
    applyStimulus(16'h1234, 16'h1229, 1'b0);
    applyStimulus(16'h8000, 16'h7FF5, 1'b0);
    applyStimulus(16'h0005, 16'hFFFA, 1'b0);
    tick(10);
    checkOutput("full_in_ready", 32'(in_ready), 32'd0);
    checkOutput("full_out_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    applyStimulus(16'hFFFF, 16'hFFF4, 1'b0);
    waitDrain("drain_full");
    exp_jobs += 6;
    checkOutput("jobs_full", 32'(jobs_done), 32'(exp_jobs));

    $display("[TB] output backpressure");
    core_lat = 5;
    out_ready = 1'b0;
    applyStimulus(16'h0A0A, 16'h09FF, 1'b0);
    applyStimulus(16'h0B00, 16'h0AF5, 1'b0);
    n = 0;
    while (!out_valid && n < 100) begin tick(1); n++; end
    checkOutput("bp_first_valid", 32'(out_valid), 32'd1);
    s0 = start_cnt;
    tick(15);
    checkOutput("bp_no_start", 32'(start_cnt), 32'(s0));
    out_ready = 1'b1;
    tick(4);
    checkOutput("bp_restart", 32'(start_cnt), 32'(s0 + 1));
    waitDrain("drain_bp");
    exp_jobs += 2;

    $display("[TB] spurious done");
    core_y = 16'hDEAD;
    spur_done = 1'b1;
    tick(2);
    spur_done = 1'b0;
    checkOutput("spur_idle_jobs", 32'(jobs_done), 32'(exp_jobs));
    checkOutput("spur_idle_valid", 32'(out_valid), 32'd0);
    core_lat = 4;
    applyStimulus(16'h0042, 16'h0037, 1'b0);
    spur_done = 1'b1;
    tick(2);
    spur_done = 1'b0;
    checkOutput("spur_start_jobs", 32'(jobs_done), 32'(exp_jobs));
    checkOutput("spur_start_valid", 32'(out_valid), 32'd0);
    waitDrain("drain_spur");
    exp_jobs += 1;
    checkOutput("jobs_spur", 32'(jobs_done), 32'(exp_jobs));

    $display("[TB] reset mid-wait");
    core_lat = 0;
    applyStimulus(16'h0001, 16'h0000, 1'b0);
    applyStimulus(16'h0002, 16'h0000, 1'b0);
    applyStimulus(16'h0003, 16'h0000, 1'b0);
    applyStimulus(16'h0004, 16'h0000, 1'b0);
    tick(3);
    checkOutput("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    sb.delete();
    #2;
    checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_core_x", 32'(core_x), 32'd0);
    checkOutput("mid_rst_jobs", 32'(jobs_done), 32'd0);
    tick(2);
    rst = 1'b0;
    exp_jobs = 0;
    s0 = start_cnt;
    core_lat = 4;
    tick(30);
    checkOutput("post_rst_start", 32'(start_cnt), 32'(s0));
    checkOutput("post_rst_valid", 32'(out_valid), 32'd0);

`ifdef SEQ_TIMEOUT_EN
    $display("[TB] timeout");
    core_lat = 0;
    abort_cyc = 0;
    applyStimulus(16'h1111, 16'hFFFF, 1'b1);
    n = 0;
    while (abort_cyc == 0 && n < 100) begin tick(1); n++; end
    checkOutput("to_abort_delay", 32'(abort_cyc - start_cyc), 32'd11);
    checkOutput("to_jobs", 32'(jobs_done), 32'(exp_jobs));
    core_lat = 4;
    applyStimulus(16'h2222, 16'h2217, 1'b0);
    waitDrain("drain_timeout");
    exp_jobs += 1;
    checkOutput("jobs_timeout", 32'(jobs_done), 32'(exp_jobs));
`endif

    tick(5);
    checkOutput("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
